layer_three: RTL
================

Name: layer_three

Overview:
- Binary fully-connected classifier stage, directly downstream of the layer-2 conv/pool stage.
- Consumes the 196-bit layer-2 feature map (4 filters × 7×7) and 10 rows of 196 binary weights.
- Computes one XNOR-popcount score per digit class, processing CHUNK bits per cycle, and tracks a running argmax.
- Outputs the predicted digit (0-9) and a sticky done flag to the top-level sequencer.

Parameters:
- IN_BITS, 196: input feature width; fixed by the layer-2 output size.
- NUM_CLASSES, 10: number of output neurons (digits).
- CHUNK, 28: feature bits consumed per cycle. Must divide IN_BITS (legal values 1, 2, 4, 7, 14, 28, 49, 98, 196). Elaboration error otherwise.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- state  input  3  top-level sequencer state; block is active only when state == s_LAYER_3 (3'b100).
- features  input  196  layer-2 output; bit index = wn*49 + row*7 + col.
- weights  input  1960  FC weights; bit n*196 + i is the weight of class n for feature bit i.
- digit  output  4  predicted class index.
- done  output  1  classification complete (sticky).
- scores  output  80  class n score in bits [n*8 +: 8]; present only with LAYER_THREE_SCORES_OUT_EN.

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset clears: digit=0, done=0, scores=0, neuron counter n=0, chunk counter k=0, accumulator acc=0, best_score=0, best_idx=0. Reset mid-operation aborts the run; the next run restarts from n=0, k=0.
- features and weights must remain stable while state == s_LAYER_3 and done == 0.
- Active cycle: state == s_LAYER_3 and done == 0. Each active cycle:
  - part = popcount(~(features[k*CHUNK +: CHUNK] ^ weights[n*IN_BITS + k*CHUNK +: CHUNK])).
  - If k < IN_BITS/CHUNK - 1: acc <= acc + part; k <= k + 1.
  - Else (last chunk):
    - score = acc + part (8-bit; maximum 196, no overflow).
    - If n == 0 or score > best_score: best_score <= score; best_idx <= n. Strict greater-than, so ties resolve to the lowest index.
    - acc <= 0; k <= 0; n <= n + 1.
    - If n == NUM_CLASSES-1: digit <= final argmax index (including this neuron) and done <= 1 on the same edge.
- Latency: NUM_CLASSES × IN_BITS/CHUNK active cycles (70 at defaults). done is high after the 70th active edge.
- state != s_LAYER_3 while busy: all counters and accumulators hold (pause); processing resumes seamlessly when state returns.
- After done: the block is idle, done remains 1, and digit is frozen until reset.
- digit is written only at completion. It reads 0 before completion.

Optional Feature:
- LAYER_THREE_SCORES_OUT_EN defined:
  - scores port exists.
  - Each class's final score is registered into scores[n*8 +: 8] on that class's last-chunk edge.
  - Scores are reset to 0.
- Not defined:
  - No scores port and no score storage; only best_score/best_idx are kept.
  - Counting, latency and digit behaviour are identical to the defined case.

Decomposition:
- Shared package bnn_pkg holds:
  - state encodings (s_LAYER_1..s_LAYER_3, s_DONE), e.g. s_LAYER_2=3'b011, s_LAYER_3=3'b100;
  - size constants L2_OUT_BITS=196, NUM_CLASSES=10, SCORE_W=8.
- One sub-module: xnor_popcount, parameterised by width W. Combinational; inputs a[W-1:0], b[W-1:0]; output popcount(~(a^b)) on $clog2(W+1) bits. It is reused by earlier layers.
- Control (counters, argmax) stays in layer_three.

Test Plan:
- Neuron 3 wins: features all 1; class-3 weights all 1, others all 0; state held at 3'b100 → done=1 exactly after 70 active edges, digit=3, scores[3]=196 and others 0 (with macro).
- Tie: all weights identical (all 0), features = alternating 1010… → every score 98; digit=0.
- Pause: state leaves 3'b100 for 5 cycles at active cycle 30 → done rises at cycle 75, digit unchanged vs. the uninterrupted run; counters frozen during the gap.
- Reset mid-run: rst_n=0 for 1 cycle at active cycle 40 → digit=0, done=0; rerun completes 70 cycles later with the correct digit.
- CHUNK=196 build: same stimulus as the neuron-3 test → done after 10 active cycles, digit=3.
- Last-class win and sticky done: class-9 weights all 1, others all 0, features all 1 → digit=9. Holding state for 20 extra cycles keeps done=1 and digit=9 unchanged.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural network pipeline: sequencer state
// encodings and layer size constants used by every layer stage.
package bnn_pkg;

    typedef enum logic [2:0] {
        s_IDLE    = 3'b000,
        s_LOAD    = 3'b001,
        s_LAYER_1 = 3'b010,
        s_LAYER_2 = 3'b011,
        s_LAYER_3 = 3'b100,
        s_DONE    = 3'b101
    } bnn_state_e;

    localparam int L2_OUT_BITS = 196;
    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 8;

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR-popcount: number of bit positions where a and b agree.
module xnor_popcount #(
    parameter int W = 28
) (
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    output logic [$clog2(W+1)-1:0]   cnt
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0] agree;

    always_comb begin
        agree = ~(a ^ b);
        cnt   = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(agree[i]);
        end
    end

endmodule

// File: rtl/layer_three.sv
// Binary fully-connected classifier: chunked XNOR-popcount per class with a
// running argmax. Optional per-class score port: LAYER_THREE_SCORES_OUT_EN.
module layer_three
    import bnn_pkg::*;
#(
    parameter int IN_BITS     = bnn_pkg::L2_OUT_BITS,
    parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int CHUNK       = 28
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [2:0]                         state,
    input  logic [IN_BITS-1:0]                 features,
    input  logic [NUM_CLASSES*IN_BITS-1:0]     weights,
    output logic [$clog2(NUM_CLASSES)-1:0]     digit,
`ifdef LAYER_THREE_SCORES_OUT_EN
    output logic [NUM_CLASSES*SCORE_W-1:0]     scores,
`endif
    output logic                               done
);

    localparam int NCHUNK = IN_BITS / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NW     = $clog2(NUM_CLASSES);
    localparam int PW     = $clog2(CHUNK + 1);
    localparam int FW     = $clog2(IN_BITS);
    localparam int WW     = $clog2(NUM_CLASSES * IN_BITS);

    if (IN_BITS % CHUNK != 0) begin : g_bad_chunk
        $error("layer_three: CHUNK must divide IN_BITS");
    end

    logic [NW-1:0]      n_q;
    logic [KW-1:0]      k_q;
    logic [SCORE_W-1:0] acc_q;
    logic [SCORE_W-1:0] best_score_q;
    logic [NW-1:0]      best_idx_q;
    logic [NW-1:0]      digit_q;
    logic               done_q;

    logic [FW-1:0]      f_off;
    logic [WW-1:0]      w_off;
    logic [CHUNK-1:0]   feat_chunk;
    logic [CHUNK-1:0]   wgt_chunk;
    logic [PW-1:0]      part;
    logic [SCORE_W-1:0] score_sum;
    logic               active;
    logic               last_k;
    logic               last_n;
    logic               new_best;
    logic [SCORE_W-1:0] best_score_d;
    logic [NW-1:0]      best_idx_d;

    always_comb begin
        f_off      = FW'(k_q) * FW'(CHUNK);
        w_off      = WW'(n_q) * WW'(IN_BITS) + WW'(f_off);
        feat_chunk = features[f_off +: CHUNK];
        wgt_chunk  = weights[w_off +: CHUNK];
    end

    xnor_popcount #(.W(CHUNK)) u_xnor_popcount (
        .a   (feat_chunk),
        .b   (wgt_chunk),
        .cnt (part)
    );

    // Strict greater-than keeps the lowest class index on ties.
    always_comb begin
        active       = (state == s_LAYER_3) && !done_q;
        last_k       = (k_q == KW'(NCHUNK - 1));
        last_n       = (n_q == NW'(NUM_CLASSES - 1));
        score_sum    = acc_q + SCORE_W'(part);
        new_best     = (n_q == '0) || (score_sum > best_score_q);
        best_score_d = new_best ? score_sum : best_score_q;
        best_idx_d   = new_best ? n_q : best_idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            digit_q      <= '0;
            done_q       <= 1'b0;
        end else if (active) begin
            if (!last_k) begin
                acc_q <= score_sum;
                k_q   <= k_q + 1'b1;
            end else begin
                acc_q        <= '0;
                k_q          <= '0;
                n_q          <= n_q + 1'b1;
                best_score_q <= best_score_d;
                best_idx_q   <= best_idx_d;
                if (last_n) begin
                    digit_q <= best_idx_d;
                    done_q  <= 1'b1;
                end
            end
        end
    end

`ifdef LAYER_THREE_SCORES_OUT_EN
    localparam int SW = $clog2(NUM_CLASSES * SCORE_W);

    logic [NUM_CLASSES*SCORE_W-1:0] scores_q;
    logic [SW-1:0]                  s_off;

    always_comb s_off = SW'(n_q) * SW'(SCORE_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scores_q <= '0;
        end else if (active && last_k) begin
            scores_q[s_off +: SCORE_W] <= score_sum;
        end
    end

    assign scores = scores_q;
`endif

    assign digit = digit_q;
    assign done  = done_q;

endmodule
